// File: rtl/trdb_bmap_packetizer.sv
`default_nettype none
// ============================================================================
// trdb_bmap_packetizer: snapshots the branch-map recorder into packets, queues
// them in a FIFO toward the sink and flushes the recorder after each snapshot.
// Optional build macro: TRDB_BMAP_DROP_CNT_EN (enables the drop counter).
// Revision: 1.0
// ============================================================================
module trdb_bmap_packetizer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [30:0]                   map_i,
  input  logic [4:0]                    branches_i,
  input  logic                          is_full_i,
  input  logic                          emit_i,
  output logic                          flush_o,
  output logic [37:0]                   packet_o,
  output logic                          packet_valid_o,
  input  logic                          packet_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [7:0]                    drop_cnt_o
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [37:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             flush_q, flush_d;
  logic             overflow_q, overflow_d;

  logic        cap;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [37:0] pkt;

  always_comb begin
    cap   = is_full_i | (emit_i & (branches_i != 5'd0));
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
            (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    pop   = ~empty & packet_ready_i;
    // A full FIFO still accepts a snapshot when the head leaves this cycle.
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;
    pkt   = {map_i, branches_i, 2'b01};
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    flush_d    = cap;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      flush_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      flush_q    <= flush_d;
      overflow_q <= overflow_d;
    end
  end

  // Packet storage is deliberately left unreset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= pkt;
    end
  end

`ifdef TRDB_BMAP_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 8'd0;
`endif

  assign flush_o        = flush_q;
  assign overflow_o     = overflow_q;
  assign packet_valid_o = ~empty;
  assign packet_o       = empty ? 38'd0 : mem_q[rd_ptr_q[IDX_W-1:0]];
  assign fifo_level_o   = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_trdb_bmap_packetizer.sv
`default_nettype none
// ============================================================================
// tb_trdb_bmap_packetizer: directed and randomized checks against a queue model.
// Revision: 1.0
// ============================================================================
module tb_trdb_bmap_packetizer;

  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef TRDB_BMAP_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [30:0]       map_i;
  logic [4:0]        branches_i;
  logic              is_full_i;
  logic              emit_i;
  logic              flush_o;
  logic [37:0]       packet_o;
  logic              packet_valid_o;
  logic              packet_ready_i;
  logic [LVL_W-1:0]  fifo_level_o;
  logic              overflow_o;
  logic [7:0]        drop_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [37:0] mq[$];
  logic        m_flush;
  logic        m_ovf;
  logic [7:0]  m_drop;

  trdb_bmap_packetizer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .map_i          (map_i),
    .branches_i     (branches_i),
    .is_full_i      (is_full_i),
    .emit_i         (emit_i),
    .flush_o        (flush_o),
    .packet_o       (packet_o),
    .packet_valid_o (packet_valid_o),
    .packet_ready_i (packet_ready_i),
    .fifo_level_o   (fifo_level_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [37:0] m_head();
    if (mq.size() == 0) return 38'd0;
    return mq[0];
  endfunction

  function automatic logic [LVL_W-1:0] m_level();
    return LVL_W'(mq.size());
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush = 1'b0;
    m_ovf   = 1'b0;
    m_drop  = 8'd0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic cap, pop, full;
    cap  = is_full_i | (emit_i & (branches_i != 0));
    pop  = (mq.size() != 0) && packet_ready_i;
    full = (mq.size() == FIFO_DEPTH);
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (!full || pop) mq.push_back({map_i, branches_i, 2'b01});
      else begin
        m_ovf = 1'b1;
        if (DROP_EN && m_drop != 8'd255) m_drop = m_drop + 8'd1;
      end
    end
    m_flush = cap;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    map_i = '0; branches_i = '0; is_full_i = 1'b0; emit_i = 1'b0;
  endtask

  task automatic drive_cap(input logic [30:0] m, input logic [4:0] b, input logic e);
    map_i = m; branches_i = b; is_full_i = (b == 5'd31); emit_i = e;
  endtask

  task automatic test_reset();
    idle_inputs();
    packet_ready_i = 1'b1;
    rst_ni = 1'b0;
    model_reset();
    #23;
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush actual=%0b required=0", flush_o); end
    if (packet_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid actual=%0b required=0", packet_valid_o); end
    if (fifo_level_o !== '0) begin n_fail++; $display("FAIL reset_level actual=%0d required=0", fifo_level_o); end
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf actual=%0b required=0", overflow_o); end
    if (drop_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_drop actual=%0d required=0", drop_cnt_o); end
    if (packet_o !== 38'd0) begin n_fail++; $display("FAIL reset_packet actual=%h required=0", packet_o); end
    n_checks += 6;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_full_map();
    logic [37:0] exp_pkt;
    exp_pkt = {31'h2AAAAAAA, 5'd31, 2'b01};
    packet_ready_i = 1'b1;
    drive_cap(31'h2AAAAAAA, 5'd31, 1'b0);
    cycle();
    idle_inputs();
    if (packet_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_valid actual=%0b required=1", packet_valid_o); end
    if (packet_o !== exp_pkt) begin n_fail++; $display("FAIL full_packet actual=%h required=%h", packet_o, exp_pkt); end
    if (flush_o !== 1'b1) begin n_fail++; $display("FAIL full_flush actual=%0b required=1", flush_o); end
    n_checks += 3;
    cycle();
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL full_flush_pulse actual=%0b required=0", flush_o); end
    if (packet_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_drained actual=%0b required=0", packet_valid_o); end
    n_checks += 2;
  endtask

  task automatic test_emit_partial();
    logic [37:0] exp_pkt;
    exp_pkt = {31'b10100, 5'd5, 2'b01};
    packet_ready_i = 1'b0;
    drive_cap(31'b10100, 5'd5, 1'b1);
    cycle();
    idle_inputs();
    if (packet_o !== exp_pkt) begin n_fail++; $display("FAIL emit_packet actual=%h required=%h", packet_o, exp_pkt); end
    if (flush_o !== 1'b1) begin n_fail++; $display("FAIL emit_flush actual=%0b required=1", flush_o); end
    if (fifo_level_o !== 1) begin n_fail++; $display("FAIL emit_level actual=%0d required=1", fifo_level_o); end
    n_checks += 3;
    // Single branch recorded right after the flush, emitted again.
    drive_cap(31'b1, 5'd1, 1'b1);
    cycle();
    idle_inputs();
    if (flush_o !== 1'b1) begin n_fail++; $display("FAIL emit1_flush actual=%0b required=1", flush_o); end
    if (fifo_level_o !== 2) begin n_fail++; $display("FAIL emit1_level actual=%0d required=2", fifo_level_o); end
    n_checks += 2;
    packet_ready_i = 1'b1;
    cycle();
    if (packet_o !== {31'b1, 5'd1, 2'b01}) begin n_fail++; $display("FAIL emit1_order actual=%h required=%h", packet_o, {31'b1, 5'd1, 2'b01}); end
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL emit1_flush_end actual=%0b required=0", flush_o); end
    n_checks += 2;
    cycle();
  endtask

  task automatic test_emit_zero();
    packet_ready_i = 1'b1;
    drive_cap(31'b0, 5'd0, 1'b1);
    cycle();
    idle_inputs();
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL zero_flush actual=%0b required=0", flush_o); end
    if (fifo_level_o !== 0) begin n_fail++; $display("FAIL zero_level actual=%0d required=0", fifo_level_o); end
    if (packet_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_valid actual=%0b required=0", packet_valid_o); end
    n_checks += 3;
  endtask

  task automatic test_overflow();
    logic [37:0] sent[5];
    packet_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cap(31'(i + 3), 5'd2, 1'b1);
      sent[i] = {31'(i + 3), 5'd2, 2'b01};
      cycle();
      if (fifo_level_o !== LVL_W'((i < 4) ? i + 1 : 4)) begin
        n_fail++; $display("FAIL ovf_level%0d actual=%0d required=%0d", i, fifo_level_o, (i < 4) ? i + 1 : 4);
      end
      n_checks++;
    end
    idle_inputs();
    if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag actual=%0b required=1", overflow_o); end
    if (drop_cnt_o !== (DROP_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL ovf_drop actual=%0d required=%0d", drop_cnt_o, DROP_EN ? 1 : 0); end
    n_checks += 2;
    packet_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (packet_o !== sent[i]) begin n_fail++; $display("FAIL drain%0d actual=%h required=%h", i, packet_o, sent[i]); end
      n_checks++;
      cycle();
    end
    if (packet_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty actual=%0b required=0", packet_valid_o); end
    n_checks++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] drop_before;
    packet_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cap(31'(i + 9), 5'd4, 1'b1);
      cycle();
    end
    drop_before = drop_cnt_o;
    packet_ready_i = 1'b1;
    drive_cap(31'h55, 5'd7, 1'b1);
    cycle();
    idle_inputs();
    packet_ready_i = 1'b0;
    if (fifo_level_o !== 4) begin n_fail++; $display("FAIL pp_level actual=%0d required=4", fifo_level_o); end
    if (drop_cnt_o !== drop_before) begin n_fail++; $display("FAIL pp_drop actual=%0d required=%0d", drop_cnt_o, drop_before); end
    if (packet_o !== {31'd10, 5'd4, 2'b01}) begin n_fail++; $display("FAIL pp_head actual=%h required=%h", packet_o, {31'd10, 5'd4, 2'b01}); end
    n_checks += 3;
  endtask

  task automatic test_reset_mid();
    packet_ready_i = 1'b0;
    rst_ni = 1'b0;
    #3;
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    for (int i = 0; i < 2; i++) begin
      drive_cap(31'(i + 1), 5'd3, 1'b1);
      cycle();
    end
    idle_inputs();
    if (flush_o !== 1'b1 || fifo_level_o !== 2) begin
      n_fail++; $display("FAIL rmid_setup flush=%0b level=%0d required flush=1 level=2", flush_o, fifo_level_o);
    end
    n_checks++;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL rmid_flush actual=%0b required=0", flush_o); end
    if (packet_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid actual=%0b required=0", packet_valid_o); end
    if (fifo_level_o !== 0) begin n_fail++; $display("FAIL rmid_level actual=%0d required=0", fifo_level_o); end
    if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin n_fail++; $display("FAIL rmid_ovf ovf=%0b drop=%0d required 0/0", overflow_o, drop_cnt_o); end
    if (packet_o !== 38'd0) begin n_fail++; $display("FAIL rmid_packet actual=%h required=0", packet_o); end
    n_checks += 5;
    @(negedge clk_i);
    rst_ni = 1'b1;
    packet_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (packet_valid_o !== 1'b0 || flush_o !== 1'b0) begin
        n_fail++; $display("FAIL rmid_after%0d valid=%0b flush=%0b required 0/0", i, packet_valid_o, flush_o);
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    logic [4:0] b;
    for (int i = 0; i < 400; i++) begin
      b = 5'($urandom_range(0, 31));
      map_i          = 31'($urandom) & ((31'h1 << b) - 31'h1);
      if (b == 5'd31) map_i = 31'($urandom);
      branches_i     = b;
      is_full_i      = (b == 5'd31);
      emit_i         = ($urandom_range(0, 99) < 30);
      packet_ready_i = ($urandom_range(0, 99) < 40);
      cycle();
      if (packet_o !== m_head() || packet_valid_o !== (mq.size() != 0) || fifo_level_o !== m_level()) begin
        n_fail++;
        $display("FAIL rnd_fifo cyc=%0d pkt=%h valid=%0b level=%0d required pkt=%h valid=%0b level=%0d",
                 i, packet_o, packet_valid_o, fifo_level_o, m_head(), mq.size() != 0, m_level());
      end
      if (flush_o !== m_flush || overflow_o !== m_ovf || drop_cnt_o !== m_drop) begin
        n_fail++;
        $display("FAIL rnd_status cyc=%0d flush=%0b ovf=%0b drop=%0d required flush=%0b ovf=%0b drop=%0d",
                 i, flush_o, overflow_o, drop_cnt_o, m_flush, m_ovf, m_drop);
      end
      n_checks += 2;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_map();
    test_emit_partial();
    test_emit_zero();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trdb_bmap_packetizer.md
# trdb_bmap_packetizer

Downstream consumer of the branch-map recorder in the trace debugger. It snapshots the recorder's map and branch count when the map fills or when an emit is requested, and formats the snapshot into a branch-map packet. It buffers packets in a small FIFO toward the packet sink with a valid/ready handshake. It also drives the recorder's flush input one cycle after every snapshot.

## Interface
Parameters:
- FIFO_DEPTH, default 4: packet FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- map_i  in  31  recorder map, this-cycle value; bit k = branch k NOT taken.
- branches_i  in  5  recorder branch count, this-cycle value (0..31).
- is_full_i  in  1  recorder count == 31, this cycle.
- emit_i  in  1  request to emit a partial map (e.g. alongside an address packet).
- flush_o  out  1  to recorder flush input; registered.
- packet_o  out  38  FIFO head: [1:0] format = 2'b01, [6:2] branch count, [37:7] map.
- packet_valid_o  out  1  FIFO non-empty.
- packet_ready_i  in  1  sink accepts the head this cycle.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow_o  out  1  sticky; set when a snapshot is dropped.
- drop_cnt_o  out  8  dropped-snapshot counter (see Configuration).

## Operation
- Capture condition, same cycle: cap = is_full_i | (emit_i & (branches_i != 0)).
- emit_i with branches_i == 0 produces no packet and no flush.
- On cap, the packet {map_i, branches_i, 2'b01} is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the packet is dropped: overflow_o is set and drop_cnt_o increments.
- flush_o is a flop: flush_o(N+1) = cap(N), regardless of push or drop. The recorder is always cleared, so it never exceeds 31 entries.
- flush_o is registered because the recorder has a combinational path from its flush input to its outputs; a combinational flush_o would close a loop.
- Map bits above the branch count are zero, because the recorder clears on flush.
- FIFO pop: packet_valid_o & packet_ready_i.
- packet_o, packet_valid_o and fifo_level_o are derived from registers only. There is no combinational path from packet_ready_i to any output.
- Push on full with a simultaneous pop: both occur, and the level is unchanged.
- Push on empty: the packet is visible at the head in the next cycle. There is no bypass.
- Read/write pointers have $clog2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest are equal.
- overflow_o clears only on reset.

## Timing
- Reset values:
  - flush_o = 0, packet_valid_o = 0, fifo_level_o = 0, overflow_o = 0, drop_cnt_o = 0.
  - packet_o = 0; FIFO storage is not reset, but the head reads 0 while empty.
- Capture latency: cap in cycle N → packet_valid_o high in N+1 (if the FIFO was empty), and flush_o high in N+1.
- Cycle N+1 after a capture: the recorder's outputs reflect the cleared map plus any branch recorded that cycle. is_full_i cannot be high then.
- emit_i in N+1 with branches_i == 1 captures that single branch, and flush_o pulses again in N+2.
- Reset mid-operation: the FIFO empties, any pending flush is discarded, and the counters clear immediately (asynchronously).

## Configuration
- TRDB_BMAP_DROP_CNT_EN defined: drop_cnt_o is an 8-bit counter that increments per dropped snapshot and saturates at 255.
- TRDB_BMAP_DROP_CNT_EN undefined: drop_cnt_o is tied to 0 and no counter flops exist. overflow_o behaves identically in both builds.

## Test plan
- Feed 31 branches alternating taken/not-taken into the recorder, with sink ready → packet_o = {31'h2AAAAAAA, 5'd31, 2'b01}, packet_valid_o one cycle after full, flush_o one pulse, recorder count then 0.
- 5 branches (T,T,N,T,N), then emit_i → packet with count 5 and map 31'b10100, one flush_o pulse.
- emit_i with branches_i = 0 → no push, flush_o stays 0, fifo_level_o stays 0.
- packet_ready_i low, 5 captures with FIFO_DEPTH = 4:
  - fifo_level_o reaches 4; the 5th capture is dropped, overflow_o = 1, drop_cnt_o = 1 (0 without the macro).
  - Raise ready → 4 packets drain in order, one per cycle.
- FIFO full with ready high in the same cycle as a capture → pop and push both occur, level stays 4, no overflow.
- Assert rst_ni low while 2 packets are queued and flush_o is high → all outputs return to their reset values immediately; no packet appears after reset release.
